// File: rtl/add_pipe.sv
// rtl/add_pipe.sv - pipelined carry-chunked add/subtract unit with valid/ready handshakes
module add_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             op_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int CW = WIDTH / STAGES;
    localparam int L  = STAGES - 1;

    // per-stage registered state: valid, operands still to be consumed, partial sum, carry
    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] load;
    logic [WIDTH-1:0]  a_q  [STAGES];
    logic [WIDTH-1:0]  bx_q [STAGES];
    logic [WIDTH-1:0]  s_q  [STAGES];
    logic              c_q  [STAGES];
    logic              ovf_q;
    logic              zero_q;

    // what each stage sees on its input side, and what it will register
    logic [WIDTH-1:0]  a_src  [STAGES];
    logic [WIDTH-1:0]  bx_src [STAGES];
    logic [WIDTH-1:0]  s_src  [STAGES];
    logic              c_src  [STAGES];
    logic [WIDTH-1:0]  s_nx   [STAGES];
    logic              c_nx   [STAGES];
    logic [CW:0]       chunk_t;
    logic              ovf_nx;
    logic              zero_nx;

    // ready chain, evaluated from the output backwards so a full pipe can drain and refill in one cycle
    always_comb begin
        load    = '0;
        load[L] = !v_q[L] || out_ready;
        for (int k = L - 1; k >= 0; k--) begin
            load[k] = !v_q[k] || load[k+1];
        end
    end

    assign in_ready  = load[0];
    assign out_valid = v_q[L];
    assign sum       = s_q[L];
    assign cout      = c_q[L];
    assign ovf       = ovf_q;
    assign zero      = zero_q;

    // stage inputs: stage 0 takes the ports (subtract as a + ~b + 1), later stages take the previous registers
    always_comb begin
        a_src[0]  = a;
        bx_src[0] = op_sub ? ~b : b;
        s_src[0]  = '0;
        c_src[0]  = op_sub;
        for (int k = 1; k < STAGES; k++) begin
            a_src[k]  = a_q[k-1];
            bx_src[k] = bx_q[k-1];
            s_src[k]  = s_q[k-1];
            c_src[k]  = c_q[k-1];
        end
    end

    // each stage adds its own chunk and splices it into the partial sum
    always_comb begin
        chunk_t = '0;
        for (int k = 0; k < STAGES; k++) begin
            chunk_t = {1'b0, a_src[k][k*CW +: CW]} + {1'b0, bx_src[k][k*CW +: CW]}
                    + {{CW{1'b0}}, c_src[k]};
            s_nx[k]              = s_src[k];
            s_nx[k][k*CW +: CW]  = chunk_t[CW-1:0];
            c_nx[k]              = chunk_t[CW];
        end
    end

    // flags come from the final stage so they always travel with their own sum
    always_comb begin
        ovf_nx  = a_src[L][WIDTH-1] ^ bx_src[L][WIDTH-1] ^ s_nx[L][WIDTH-1] ^ c_nx[L];
        zero_nx = (s_nx[L] == '0);
    end

    // valid bits shift forward wherever a stage is allowed to load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
        end else begin
            if (load[0]) begin
                v_q[0] <= in_valid;
            end
            for (int k = 1; k < STAGES; k++) begin
                if (load[k]) begin
                    v_q[k] <= v_q[k-1];
                end
            end
        end
    end

    // datapath registers hold whenever their stage is stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]  <= '0;
                bx_q[k] <= '0;
                s_q[k]  <= '0;
                c_q[k]  <= 1'b0;
            end
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (load[k]) begin
                    a_q[k]  <= a_src[k];
                    bx_q[k] <= bx_src[k];
                    s_q[k]  <= s_nx[k];
                    c_q[k]  <= c_nx[k];
                end
            end
            if (load[L]) begin
                ovf_q  <= ovf_nx;
                zero_q <= zero_nx;
            end
        end
    end

endmodule

// File: tb/tb_add_pipe.sv
// tb/tb_add_pipe.sv - randomized and directed self-checking bench for add_pipe
module tb_add_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, op_sub, out_valid, out_ready;
    logic [31:0] a, b, sum;
    logic        cout, ovf, zero;

    logic        in_valid8, in_ready8, op_sub8, out_valid8, out_ready8;
    logic [7:0]  a8, b8, sum8;
    logic        cout8, ovf8, zero8;

    int n_tests = 0;
    int n_fail  = 0;

    typedef logic [34:0] exp_t;   // {sum, cout, ovf, zero}
    exp_t exp_q[$];

    always #5 clk = ~clk;

    add_pipe #(.WIDTH(32), .STAGES(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op_sub(op_sub), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
    );

    add_pipe #(.WIDTH(8), .STAGES(1)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .op_sub(op_sub8), .out_valid(out_valid8), .out_ready(out_ready8),
        .sum(sum8), .cout(cout8), .ovf(ovf8), .zero(zero8)
    );

    // reference: plain wide arithmetic on unsigned and signed interpretations
    function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input logic s);
        longint      sx, sy, r;
        logic [32:0] u;
        logic [31:0] res;
        logic        c, o;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (s) begin
            r   = sx - sy;
            res = x - y;
            c   = (x >= y);
        end else begin
            r   = sx + sy;
            u   = {1'b0, x} + {1'b0, y};
            res = u[31:0];
            c   = u[32];
        end
        o = (r > 64'sd2147483647) || (r < -64'sd2147483648);
        return {res, c, o, (res == 32'd0)};
    endfunction

    // one clock: drive at the falling edge, sample 1 time unit later, return at the next falling edge
    task automatic step(input logic iv, input logic [31:0] ia, input logic [31:0] ib,
                        input logic isub, input logic ordy,
                        output logic acc, output logic got, output logic ovalid,
                        output logic irdy, output exp_t obs);
        in_valid  = iv;
        a         = ia;
        b         = ib;
        op_sub    = isub;
        out_ready = ordy;
        #1;
        acc    = in_valid && in_ready;
        got    = out_valid && out_ready;
        ovalid = out_valid;
        irdy   = in_ready;
        obs    = {sum, cout, ovf, zero};
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        a = '0; b = '0; op_sub = 1'b0;
        in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = '0; b8 = '0; op_sub8 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        n_tests++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        n_tests++;
        if ({sum, cout, ovf, zero} !== 35'd0) begin
            n_fail++; $display("FAIL reset_outputs got=%h/%b%b%b want=0", sum, cout, ovf, zero);
        end
        n_tests++;
        if ({out_valid8, in_ready8, sum8, cout8, ovf8, zero8} !== 13'b0_1_00000000_000) begin
            n_fail++; $display("FAIL reset_dut8 got v=%b r=%b s=%h", out_valid8, in_ready8, sum8);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [31:0] ta [5] = '{32'h0000_00FF, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'd3};
        logic [31:0] tb [5] = '{32'd1, 32'd1, 32'd1, 32'd1, 32'd5};
        logic        ts [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        exp_t        te [5] = '{{32'h0000_0100, 3'b000}, {32'h0000_0000, 3'b101},
                                {32'h8000_0000, 3'b010}, {32'h7FFF_FFFF, 3'b110},
                                {32'hFFFF_FFFE, 3'b000}};
        logic acc, got, ov, ir;
        exp_t obs;
        int   lat;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, ta[i], tb[i], ts[i], 1'b1, acc, got, ov, ir, obs);
            n_tests++;
            if (!acc) begin n_fail++; $display("FAIL directed%0d_accept in_ready=%b want=1", i, ir); end
            lat = 0;
            got = 1'b0;
            while (!got && lat < 10) begin
                lat++;
                step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, acc, got, ov, ir, obs);
            end
            n_tests++;
            if (lat !== 4) begin n_fail++; $display("FAIL directed%0d_latency got=%0d want=4", i, lat); end
            n_tests++;
            if (obs !== te[i]) begin
                n_fail++;
                $display("FAIL directed%0d_result got=%h/%b want=%h/%b", i, obs[34:3], obs[2:0], te[i][34:3], te[i][2:0]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic acc, got, ov, ir, ordy, prev_stall;
        exp_t obs, prev_obs, e;
        int   sent, rcvd, occ, errs_rdy, errs_hold, errs_data;
        sent = 0; rcvd = 0; occ = 0; errs_rdy = 0; errs_hold = 0; errs_data = 0;
        prev_stall = 1'b0; prev_obs = '0;
        exp_q.delete();
        for (int s = 0; s < 60 && rcvd < 8; s++) begin
            ordy = !(s >= 5 && s <= 9);
            step(sent < 8, sent, 32'h10 * sent, 1'b0, ordy, acc, got, ov, ir, obs);
            if (ir !== (ordy || occ < 4)) begin
                errs_rdy++;
                $display("FAIL bp_in_ready step=%0d got=%b held=%0d", s, ir, occ);
            end
            if (prev_stall && obs !== prev_obs) begin
                errs_hold++;
                $display("FAIL bp_hold step=%0d got=%h want=%h", s, obs[34:3], prev_obs[34:3]);
            end
            if (acc) begin exp_q.push_back(model(sent, 32'h10 * sent, 1'b0)); sent++; occ++; end
            if (got) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 35'h7_FFFF_FFFF;
                if (obs !== e) begin
                    errs_data++;
                    $display("FAIL bp_order beat=%0d got=%h want=%h", rcvd, obs[34:3], e[34:3]);
                end
                rcvd++; occ--;
            end
            prev_stall = ov && !ordy;
            prev_obs   = obs;
        end
        n_tests++;
        if (rcvd !== 8) begin n_fail++; $display("FAIL bp_count got=%0d want=8", rcvd); end
        n_tests++;
        if (errs_rdy !== 0) begin n_fail++; $display("FAIL bp_in_ready_total got=%0d want=0", errs_rdy); end
        n_tests++;
        if (errs_hold !== 0) begin n_fail++; $display("FAIL bp_hold_total got=%0d want=0", errs_hold); end
        n_tests++;
        if (errs_data !== 0) begin n_fail++; $display("FAIL bp_order_total got=%0d want=0", errs_data); end
    endtask

    task automatic test_random();
        logic        acc, got, ov, ir, ordy, iv, isub, prev_stall;
        logic [31:0] ra, rb;
        exp_t        obs, prev_obs, e;
        int          occ, errs, rcvd, sent;
        occ = 0; errs = 0; rcvd = 0; sent = 0;
        prev_stall = 1'b0; prev_obs = '0;
        exp_q.delete();
        for (int s = 0; s < 420; s++) begin
            iv   = (s < 400) && ($urandom_range(0, 3) != 0);
            ordy = (s >= 400) || ($urandom_range(0, 3) != 0);
            ra   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
            rb   = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            isub = $urandom_range(0, 1) == 1;
            step(iv, ra, rb, isub, ordy, acc, got, ov, ir, obs);
            if (ir !== (ordy || occ < 4)) begin
                errs++; $display("FAIL rand_in_ready step=%0d got=%b held=%0d", s, ir, occ);
            end
            if (prev_stall && obs !== prev_obs) begin
                errs++; $display("FAIL rand_hold step=%0d got=%h want=%h", s, obs[34:3], prev_obs[34:3]);
            end
            if (acc) begin exp_q.push_back(model(ra, rb, isub)); occ++; sent++; end
            if (got) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 35'h7_FFFF_FFFF;
                if (obs !== e) begin
                    errs++;
                    $display("FAIL rand_result beat=%0d got=%h/%b want=%h/%b", rcvd, obs[34:3], obs[2:0], e[34:3], e[2:0]);
                end
                occ--; rcvd++;
            end
            prev_stall = ov && !ordy;
            prev_obs   = obs;
        end
        n_tests++;
        if (errs !== 0) begin n_fail++; $display("FAIL rand_errors got=%0d want=0", errs); end
        n_tests++;
        if (rcvd !== sent || sent < 100) begin
            n_fail++; $display("FAIL rand_drain got=%0d want=%0d", rcvd, sent);
        end
    endtask

    task automatic test_reset_mid();
        logic acc, got, ov, ir;
        exp_t obs;
        int   lat, stale;
        for (int i = 0; i < 3; i++) step(1'b1, 32'hAA00 + i, 32'd7, 1'b0, 1'b0, acc, got, ov, ir, obs);
        for (int i = 0; i < 2; i++) step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, acc, got, ov, ir, obs);
        n_tests++;
        if (ov !== 1'b1) begin n_fail++; $display("FAIL rstmid_prefill out_valid=%b want=1", ov); end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_async got v=%b r=%b want v=0 r=1", out_valid, in_ready);
        end
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        step(1'b1, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b1, acc, got, ov, ir, obs);
        n_tests++;
        if (!acc) begin n_fail++; $display("FAIL rstmid_accept in_ready=%b want=1", ir); end
        lat = 0; stale = 0; got = 1'b0;
        while (!got && lat < 10) begin
            lat++;
            step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, acc, got, ov, ir, obs);
            if (got && lat < 4) stale++;
        end
        n_tests++;
        if (lat !== 4 || stale !== 0) begin
            n_fail++; $display("FAIL rstmid_latency got=%0d stale=%0d want=4 stale=0", lat, stale);
        end
        n_tests++;
        if (obs !== {32'h2345_6789, 3'b000}) begin
            n_fail++; $display("FAIL rstmid_result got=%h want=23456789", obs[34:3]);
        end
    endtask

    task automatic test_corner8();
        in_valid8  = 1'b1;
        a8         = 8'h7F;
        b8         = 8'h01;
        op_sub8    = 1'b0;
        out_ready8 = 1'b1;
        #1;
        n_tests++;
        if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0) begin
            n_fail++; $display("FAIL s1_pre got r=%b v=%b want r=1 v=0", in_ready8, out_valid8);
        end
        @(negedge clk);
        in_valid8 = 1'b0;
        n_tests++;
        if ({out_valid8, sum8, cout8, ovf8, zero8} !== {1'b1, 8'h80, 3'b010}) begin
            n_fail++;
            $display("FAIL s1_result got v=%b s=%h c=%b o=%b z=%b want v=1 s=80 c=0 o=1 z=0",
                     out_valid8, sum8, cout8, ovf8, zero8);
        end
        @(negedge clk);
        n_tests++;
        if (out_valid8 !== 1'b0) begin n_fail++; $display("FAIL s1_drain got=%b want=0", out_valid8); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_random();
        test_reset_mid();
        test_corner8();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
